decode_sequencer: RTL
=====================

DECODE_SEQUENCER -- requirements
Module: decode_sequencer

Interface
REQ-001 SHALL have parameter MAX_LEN, default 12'd4095, meaning maximum accepted SIGNAL LENGTH in bytes.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16'd20000, meaning maximum idle cycles allowed between decoded bytes.
REQ-003 SHALL have port clock, input, 1, the single clock for all logic.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, one-cycle pulse meaning long preamble sync is complete.
REQ-006 SHALL have port abort, input, 1, level request to abandon the current packet.
REQ-007 SHALL have ports byte_in (input, 8) and byte_in_strobe (input, 1), the decoded byte stream, LSB = first bit on air.
REQ-008 SHALL have ports dec_reset (output, 1) and dec_enable (output, 1), the decoder pipeline reset and enable.
REQ-009 SHALL have ports rate (output, 8), do_descramble (output, 1) and num_bits_to_decode (output, 20), the decoder configuration.
REQ-010 SHALL have ports sig_valid (output, 1) and sig_error (output, 1), one-cycle SIGNAL check result pulses.
REQ-011 SHALL have ports pkt_rate (output, 4) and pkt_len (output, 12), the latched SIGNAL fields.
REQ-012 SHALL have ports data_byte (output, 8) and data_byte_strobe (output, 1), the forwarded payload bytes.
REQ-013 SHALL have ports byte_count (output, 12), pkt_done (output, 1, pulse), timeout (output, 1, pulse) and busy (output, 1, high when state is not IDLE).

Function
REQ-014 SHALL implement the states IDLE, SIG_RST, SIG_DEC, SIG_CHK, DATA_RST, DATA_DEC, DONE and ERR.
REQ-015 SHALL leave IDLE only on start, going to SIG_RST; start SHALL be ignored in every other state.
REQ-016 SHALL, in SIG_RST, assert dec_reset for exactly one cycle, drive rate=8'h0B, do_descramble=0 and num_bits_to_decode=24, then go to SIG_DEC.
REQ-017 SHALL, in SIG_DEC, hold dec_enable=1 and capture bytes 0, 1 and 2 into a 24-bit SIGNAL register at bits [7:0], [15:8] and [23:16].
REQ-018 SHALL, on the third byte strobe, go to SIG_CHK with dec_enable=0 in that same following cycle.
REQ-019 SHALL, in SIG_CHK (one cycle), pass the SIGNAL field only if all of the following hold: bit3=1 (valid rate code), bit4=0 (reserved), XOR of bits [17:0] is 0 (even parity), bits [23:18] are 0 (tail), and LENGTH=bits[16:5] with 1 <= LENGTH <= MAX_LEN.
REQ-020 SHALL, on a pass, pulse sig_valid, latch pkt_rate=bits[3:0] and pkt_len=LENGTH, and go to DATA_RST.
REQ-021 SHALL, on a fail, pulse sig_error and go to ERR.
REQ-022 SHALL, in DATA_RST, assert dec_reset for one cycle, drive rate={4'b0,pkt_rate}, do_descramble=1 and num_bits_to_decode=22+(pkt_len<<3) (20-bit, no overflow), and clear byte_count.
REQ-023 SHALL, in DATA_DEC, hold dec_enable=1 and forward each strobed byte to data_byte/data_byte_strobe one cycle later, incrementing byte_count.
REQ-024 SHALL, when byte_count reaches pkt_len, go to DONE, pulse pkt_done one cycle, then return to IDLE; bytes arriving in DONE SHALL be dropped.
REQ-025 SHALL use a timeout counter that clears on entry to SIG_DEC or DATA_DEC and on every byte_in_strobe; on reaching TIMEOUT_CYCLES it SHALL pulse timeout and go to ERR.
REQ-026 SHALL, in ERR, hold dec_enable=0 for one cycle and then go to IDLE.
REQ-027 SHALL make abort, in any non-IDLE state, go to IDLE next cycle with dec_enable=0 and no pkt_done.
REQ-028 SHALL give abort priority when abort coincides with byte_in_strobe or with timeout; that byte SHALL NOT be forwarded.
REQ-029 SHALL ignore byte_in_strobe in IDLE, SIG_RST, SIG_CHK, DATA_RST and ERR.
REQ-030 SHALL hold rate, do_descramble, num_bits_to_decode, pkt_rate and pkt_len stable until the next SIG_RST or DATA_RST.

Reset
REQ-031 SHALL, on reset, force IDLE and drive every output to 0, except rate=8'h0B and num_bits_to_decode=24.
REQ-032 SHALL let reset override start, abort and byte strobes in the same cycle.
REQ-033 SHALL let reset asserted mid-packet abandon the packet without a pkt_done or sig_error pulse.

Verification
REQ-034 SHALL cover: start, then bytes 8'h8B,8'h00,8'h00 (rate 0xB, LEN=4, parity ok), then 4 bytes -> sig_valid; rate=8'h0B; num_bits_to_decode=54; 4 data_byte_strobe; pkt_done; IDLE.
REQ-035 SHALL cover: SIGNAL bytes 8'h8B,8'h00,8'h02 (parity bit set, fails) -> sig_error pulse; no DATA_RST; busy low 2 cycles after SIG_CHK.
REQ-036 SHALL cover: SIGNAL with rate 0x7 -> sig_error; SIGNAL with LEN=0 -> sig_error.
REQ-037 SHALL cover: TIMEOUT_CYCLES=100 and a DATA_DEC stall of 100 cycles -> timeout pulse; ERR; IDLE; byte_count frozen.
REQ-038 SHALL cover: abort asserted together with the 2nd data byte strobe -> that byte not forwarded; IDLE next cycle; a later start is accepted normally.
REQ-039 SHALL cover: reset pulse during SIG_DEC -> all outputs at reset values the next cycle; a subsequent full packet decodes correctly.

Source files
------------

// File: rtl/decode_sequencer.sv
// Packet decode sequencer: drives a downstream bit decoder through the SIGNAL
// field and then the payload, checks SIGNAL, forwards payload bytes and flags errors.
module decode_sequencer #(
  parameter logic [11:0] MAX_LEN        = 12'd4095,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd20000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  byte_in,
  input  logic        byte_in_strobe,
  output logic        dec_reset,
  output logic        dec_enable,
  output logic [7:0]  rate,
  output logic        do_descramble,
  output logic [19:0] num_bits_to_decode,
  output logic        sig_valid,
  output logic        sig_error,
  output logic [3:0]  pkt_rate,
  output logic [11:0] pkt_len,
  output logic [7:0]  data_byte,
  output logic        data_byte_strobe,
  output logic [11:0] byte_count,
  output logic        pkt_done,
  output logic        timeout,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_SIG_RST, S_SIG_DEC, S_SIG_CHK, S_DATA_RST, S_DATA_DEC, S_DONE, S_ERR
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic [23:0] r_signal;
  logic [1:0]  r_sig_idx;
  logic [15:0] r_idle_cnt;
  logic [7:0]  r_rate;
  logic        r_do_descramble;
  logic [19:0] r_num_bits;
  logic        r_sig_valid;
  logic        r_sig_error;
  logic        r_timeout;
  logic [3:0]  r_pkt_rate;
  logic [11:0] r_pkt_len;
  logic [7:0]  r_data_byte;
  logic        r_data_strobe;
  logic [11:0] r_byte_count;

  logic [11:0] w_sig_len;
  logic        w_sig_pass;
  logic        w_in_dec;
  logic        w_enter_dec;
  logic        w_timeout_hit;
  logic        w_byte_take;
  logic        w_last_sig;
  logic        w_last_data;

  assign w_sig_len     = r_signal[16:5];
  assign w_sig_pass    = r_signal[3] && !r_signal[4] && !(^r_signal[17:0]) &&
                         (r_signal[23:18] == 6'd0) && (w_sig_len != 12'd0) &&
                         (w_sig_len <= MAX_LEN);
  assign w_in_dec      = (r_state == S_SIG_DEC) || (r_state == S_DATA_DEC);
  assign w_enter_dec   = (r_state == S_SIG_RST) || (r_state == S_DATA_RST);
  // Idle counter value N means N strobe-free cycles already spent in a decode state.
  assign w_timeout_hit = w_in_dec && !byte_in_strobe &&
                         (r_idle_cnt == TIMEOUT_CYCLES - 16'd1);
  assign w_byte_take   = byte_in_strobe && !abort;
  assign w_last_sig    = (r_state == S_SIG_DEC) && byte_in_strobe && (r_sig_idx == 2'd2);
  assign w_last_data   = (r_state == S_DATA_DEC) && byte_in_strobe &&
                         (r_byte_count + 12'd1 == r_pkt_len);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (abort && (r_state != S_IDLE)) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:     if (start) w_next_state = S_SIG_RST;
        S_SIG_RST:  w_next_state = S_SIG_DEC;
        S_SIG_DEC: begin
          if (w_last_sig) w_next_state = S_SIG_CHK;
          else if (w_timeout_hit) w_next_state = S_ERR;
        end
        S_SIG_CHK:  w_next_state = w_sig_pass ? S_DATA_RST : S_ERR;
        S_DATA_RST: w_next_state = S_DATA_DEC;
        S_DATA_DEC: begin
          if (w_last_data) w_next_state = S_DONE;
          else if (w_timeout_hit) w_next_state = S_ERR;
        end
        S_DONE:     w_next_state = S_IDLE;
        S_ERR:      w_next_state = S_IDLE;
        default:    w_next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    dec_reset  = 1'b0;
    dec_enable = 1'b0;
    pkt_done   = 1'b0;
    busy       = 1'b1;
    case (r_state)
      S_IDLE:                busy       = 1'b0;
      S_SIG_RST, S_DATA_RST: dec_reset  = 1'b1;
      S_SIG_DEC, S_DATA_DEC: dec_enable = 1'b1;
      S_DONE:                pkt_done   = 1'b1;
      default:               ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_signal        <= 24'd0;
      r_sig_idx       <= 2'd0;
      r_idle_cnt      <= 16'd0;
      r_rate          <= 8'h0B;
      r_do_descramble <= 1'b0;
      r_num_bits      <= 20'd24;
      r_sig_valid     <= 1'b0;
      r_sig_error     <= 1'b0;
      r_timeout       <= 1'b0;
      r_pkt_rate      <= 4'd0;
      r_pkt_len       <= 12'd0;
      r_data_byte     <= 8'd0;
      r_data_strobe   <= 1'b0;
      r_byte_count    <= 12'd0;
    end else begin
      r_sig_valid   <= 1'b0;
      r_sig_error   <= 1'b0;
      r_timeout     <= 1'b0;
      r_data_strobe <= 1'b0;

      // Decoder configuration is loaded as the RST state is entered so it is valid during it.
      if (w_next_state == S_SIG_RST) begin
        r_rate          <= 8'h0B;
        r_do_descramble <= 1'b0;
        r_num_bits      <= 20'd24;
        r_sig_idx       <= 2'd0;
        r_signal        <= 24'd0;
      end
      if (w_next_state == S_DATA_RST) begin
        r_sig_valid     <= 1'b1;
        r_pkt_rate      <= r_signal[3:0];
        r_pkt_len       <= w_sig_len;
        r_rate          <= {4'd0, r_signal[3:0]};
        r_do_descramble <= 1'b1;
        r_num_bits      <= 20'd22 + {5'd0, w_sig_len, 3'd0};
      end
      if ((r_state == S_SIG_CHK) && (w_next_state == S_ERR)) begin
        r_sig_error <= 1'b1;
      end
      if (w_in_dec && (w_next_state == S_ERR)) begin
        r_timeout <= 1'b1;
      end

      if (w_enter_dec || (w_in_dec && byte_in_strobe)) begin
        r_idle_cnt <= 16'd0;
      end else if (w_in_dec) begin
        r_idle_cnt <= r_idle_cnt + 16'd1;
      end

      if ((r_state == S_SIG_DEC) && w_byte_take) begin
        case (r_sig_idx)
          2'd0:    r_signal[7:0]   <= byte_in;
          2'd1:    r_signal[15:8]  <= byte_in;
          default: r_signal[23:16] <= byte_in;
        endcase
        r_sig_idx <= r_sig_idx + 2'd1;
      end

      if (r_state == S_DATA_RST) begin
        r_byte_count <= 12'd0;
      end else if ((r_state == S_DATA_DEC) && w_byte_take) begin
        r_data_byte   <= byte_in;
        r_data_strobe <= 1'b1;
        r_byte_count  <= r_byte_count + 12'd1;
      end
    end
  end

  assign rate               = r_rate;
  assign do_descramble      = r_do_descramble;
  assign num_bits_to_decode = r_num_bits;
  assign sig_valid          = r_sig_valid;
  assign sig_error          = r_sig_error;
  assign pkt_rate           = r_pkt_rate;
  assign pkt_len            = r_pkt_len;
  assign data_byte          = r_data_byte;
  assign data_byte_strobe   = r_data_strobe;
  assign byte_count         = r_byte_count;
  assign timeout            = r_timeout;

endmodule
